// File: rtl/word_bit_serializer_if.sv
// ---------------------------------------------------------------------------
// word_bit_serializer_if
//   Bundles the word-side valid/ready handshake and the bit-side framed
//   stream of the word bit serializer.
//
//   Signals
//     in_valid   producer -> serializer  in_data holds a word
//     in_ready   serializer -> producer  word can be accepted this cycle
//     in_data    producer -> serializer  WIDTH-bit word, MSB sent first
//     bit_out    serializer -> consumer  serial data bit
//     bit_valid  serializer -> consumer  bit_out carries a word bit
//     bit_first  serializer -> consumer  first bit of a word
//     bit_last   serializer -> consumer  last bit of a word
//     busy       serializer -> consumer  a word is being shifted out
//
//   Modports
//     master : the side that drives words in and watches the bit stream
//     slave  : the serializer itself
// ---------------------------------------------------------------------------
interface word_bit_serializer_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             bit_out;
   logic             bit_valid;
   logic             bit_first;
   logic             bit_last;
   logic             busy;

   modport master (
      output in_valid,
      output in_data,
      input  in_ready,
      input  bit_out,
      input  bit_valid,
      input  bit_first,
      input  bit_last,
      input  busy
   );

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready,
      output bit_out,
      output bit_valid,
      output bit_first,
      output bit_last,
      output busy
   );
endinterface

// File: rtl/word_bit_serializer.sv
// ---------------------------------------------------------------------------
// word_bit_serializer
//   Parallel-to-serial front end for the serial mod-5 divisibility checker.
//   Words are accepted over a valid/ready handshake and emitted one bit per
//   clock, MSB first, with bit_first/bit_last framing so the checker can
//   restart its remainder per word and sample its result on the last bit.
//   in_ready is raised during the last bit of a word so back-to-back words
//   stream with no idle cycle in between.
//
//   Parameters
//     WIDTH  bits per input word (1..32)
//     CNT_W  width of the remaining-bit counter (derived, do not override)
//
//   Ports
//     clk    rising-edge clock
//     reset  synchronous, active-high reset
//     bus    word_bit_serializer_if.slave (handshake in, framed stream out)
//
//   Build option
//     SER_SKIP_LZ_EN  when defined, leading zero bits of each word are
//                     skipped; an all-zero word emits a single 0 bit marked
//                     both first and last. Leading zeros never change a
//                     mod-5 remainder, so checker results are unaffected.
// ---------------------------------------------------------------------------
module word_bit_serializer #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   word_bit_serializer_if.slave  bus
);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           state_p0, state_nx;
   logic [WIDTH-1:0] sreg_p0, sreg_nx;
   logic [CNT_W-1:0] cnt_p0, cnt_nx;
   logic             first_p0, first_nx;

   logic             last_bit;
   logic             accept;
   logic [WIDTH-1:0] load_sreg;
   logic [CNT_W-1:0] load_cnt;

`ifdef SER_SKIP_LZ_EN
   // Index of the highest set bit; an all-zero word maps to index 0 so it
   // still emits exactly one (zero) bit.
   function automatic logic [CNT_W-1:0] msb_index(input logic [WIDTH-1:0] d);
      logic [CNT_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (d[i]) idx = CNT_W'(i);
      end
      return idx;
   endfunction

   // Left-justify the word so its highest set bit sits at the shift MSB.
   function automatic logic [WIDTH-1:0] align_msb(input logic [WIDTH-1:0] d,
                                                  input logic [CNT_W-1:0] idx);
      return d << (WIDTH - 1 - int'(idx));
   endfunction
`endif

   // ---- capture path: what a newly accepted word loads ----
   always_comb begin
`ifdef SER_SKIP_LZ_EN
      load_cnt  = msb_index(bus.in_data);
      load_sreg = align_msb(bus.in_data, load_cnt);
`else
      load_cnt  = LAST_CNT;
      load_sreg = bus.in_data;
`endif
   end

   // cnt_p0 holds the number of bits still to come after the current one,
   // so the current bit is the last when it reaches zero.
   assign last_bit     = (state_p0 == SHIFT) && (cnt_p0 == '0);
   assign bus.in_ready = !reset && ((state_p0 == IDLE) || last_bit);
   assign accept       = bus.in_valid && bus.in_ready;

   // ---- next-state logic ----
   always_comb begin
      state_nx = state_p0;
      sreg_nx  = sreg_p0;
      cnt_nx   = cnt_p0;
      first_nx = 1'b0;
      case (state_p0)
         IDLE: begin
            if (accept) begin
               state_nx = SHIFT;
               sreg_nx  = load_sreg;
               cnt_nx   = load_cnt;
               first_nx = 1'b1;
            end
         end
         SHIFT: begin
            if (last_bit) begin
               if (accept) begin
                  // chain straight into the next word, no idle cycle
                  sreg_nx  = load_sreg;
                  cnt_nx   = load_cnt;
                  first_nx = 1'b1;
               end else begin
                  state_nx = IDLE;
                  sreg_nx  = '0;
                  cnt_nx   = '0;
               end
            end else begin
               sreg_nx = sreg_p0 << 1;
               cnt_nx  = cnt_p0 - CNT_ONE;
            end
         end
         default: begin
            state_nx = IDLE;
            sreg_nx  = '0;
            cnt_nx   = '0;
         end
      endcase
   end

   // ---- stage p0: shift state registers ----
   always_ff @(posedge clk) begin
      if (reset) begin
         state_p0 <= IDLE;
         sreg_p0  <= '0;
         cnt_p0   <= '0;
         first_p0 <= 1'b0;
      end else begin
         state_p0 <= state_nx;
         sreg_p0  <= sreg_nx;
         cnt_p0   <= cnt_nx;
         first_p0 <= first_nx;
      end
   end

   // ---- outputs, decoded straight from p0 registers ----
   assign bus.bit_valid = (state_p0 == SHIFT);
   assign bus.bit_out   = bus.bit_valid && sreg_p0[WIDTH-1];
   assign bus.bit_first = first_p0;
   assign bus.bit_last  = last_bit;
   assign bus.busy      = bus.bit_valid;

endmodule
